// File: rtl/ps_video_pkg.sv
// Shared constants for the greyscale video path: output modes, direction codes,
// Sobel weights and width helpers for the gradient datapath.
package ps_video_pkg;

  localparam logic [1:0] MODE_THRESH = 2'd0;
  localparam logic [1:0] MODE_MAG_L1 = 2'd1;
  localparam logic [1:0] MODE_ABS_GX = 2'd2;
  localparam logic [1:0] MODE_ABS_GY = 2'd3;

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  localparam int SOBEL_W [3] = '{1, 2, 1};

  // |G| <= 4*(2^data_w-1) needs data_w+2 magnitude bits plus a sign bit
  function automatic int g_width(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int sq_width(input int data_w);
    return 2 * data_w + 5;
  endfunction

endpackage

// File: rtl/ps_edge_grad.sv
// Stages S1-S2 of the edge filter: 3x3 window -> weighted differences -> signed Gx/Gy.
// Beat valid, SOF and the per-beat mode/threshold ride alongside, advancing only on adv.
module ps_edge_grad
  import ps_video_pkg::*;
#(
  parameter int  DATA_W = 8,
  localparam int G_W    = g_width(DATA_W),
  localparam int SQ_W   = sq_width(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv,
  input  logic [3*DATA_W-1:0]   r0_data,
  input  logic [3*DATA_W-1:0]   r1_data,
  input  logic [3*DATA_W-1:0]   r2_data,
  input  logic                  valid,
  input  logic                  sof,
  input  logic [1:0]            mode,
  input  logic [SQ_W-1:0]       thr,
  output logic signed [G_W-1:0] gx,
  output logic signed [G_W-1:0] gy,
  output logic                  grad_valid,
  output logic                  grad_sof,
  output logic [1:0]            grad_mode,
  output logic [SQ_W-1:0]       grad_thr
);

  logic [DATA_W-1:0]     p [3][3];
  logic signed [G_W-1:0] tx [3];
  logic signed [G_W-1:0] ty [3];
  logic signed [G_W-1:0] tx_q [3];
  logic signed [G_W-1:0] ty_q [3];
  logic                  v1;
  logic                  sof1;
  logic [1:0]            mode1;
  logic [SQ_W-1:0]       thr1;

  // tx[k]: row k horizontal difference, ty[k]: column k vertical difference
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      p[0][c] = r0_data[c*DATA_W +: DATA_W];
      p[1][c] = r1_data[c*DATA_W +: DATA_W];
      p[2][c] = r2_data[c*DATA_W +: DATA_W];
    end
    for (int k = 0; k < 3; k++) begin
      tx[k] = G_W'(SOBEL_W[k] * (int'(p[k][0]) - int'(p[k][2])));
      ty[k] = G_W'(SOBEL_W[k] * (int'(p[0][k]) - int'(p[2][k])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        tx_q[k] <= '0;
        ty_q[k] <= '0;
      end
      v1         <= 1'b0;
      sof1       <= 1'b0;
      mode1      <= '0;
      thr1       <= '0;
      gx         <= '0;
      gy         <= '0;
      grad_valid <= 1'b0;
      grad_sof   <= 1'b0;
      grad_mode  <= '0;
      grad_thr   <= '0;
    end else if (adv) begin
      for (int k = 0; k < 3; k++) begin
        tx_q[k] <= tx[k];
        ty_q[k] <= ty[k];
      end
      v1         <= valid;
      sof1       <= sof;
      mode1      <= mode;
      thr1       <= thr;
      gx         <= tx_q[0] + tx_q[1] + tx_q[2];
      gy         <= ty_q[0] + ty_q[1] + ty_q[2];
      grad_valid <= v1;
      grad_sof   <= sof1;
      grad_mode  <= mode1;
      grad_thr   <= thr1;
    end
  end

endmodule

// File: rtl/ps_edge_filter.sv
// Sobel edge filter top: handshake, SOF config latch, S3 (|G|, G^2) and S4 (mode mux).
// Optional gradient direction output is built only when PS_EDGE_DIR_EN is defined.
module ps_edge_filter
  import ps_video_pkg::*;
#(
  parameter int  DATA_W = 8,
  localparam int G_W    = g_width(DATA_W),
  localparam int SQ_W   = sq_width(DATA_W)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [3*DATA_W-1:0] i_r0_data,
  input  logic [3*DATA_W-1:0] i_r1_data,
  input  logic [3*DATA_W-1:0] i_r2_data,
  input  logic                i_sof,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [1:0]          i_mode,
  input  logic [SQ_W-1:0]     i_threshold,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_sof,
  output logic                o_valid,
  input  logic                i_ready
`ifdef PS_EDGE_DIR_EN
  ,
  output logic [1:0]          o_dir
`endif
);

  localparam int A_W = G_W - 1;
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  logic                  adv;
  logic [1:0]            mode_q;
  logic [SQ_W-1:0]       thr_q;
  logic [1:0]            mode_in;
  logic [SQ_W-1:0]       thr_in;
  logic signed [G_W-1:0] gx;
  logic signed [G_W-1:0] gy;
  logic                  v2;
  logic                  sof2;
  logic [1:0]            mode2;
  logic [SQ_W-1:0]       thr2;
  logic [A_W-1:0]        ax;
  logic [A_W-1:0]        ay;
  logic [SQ_W-1:0]       sq;
  logic [A_W-1:0]        ax3;
  logic [A_W-1:0]        ay3;
  logic [SQ_W-1:0]       sq3;
  logic                  v3;
  logic                  sof3;
  logic [1:0]            mode3;
  logic [SQ_W-1:0]       thr3;
  logic [A_W:0]          l1;
  logic [DATA_W-1:0]     pix;

  function automatic logic [DATA_W-1:0] sat_pix(input logic [A_W:0] v);
    return (|v[A_W:DATA_W]) ? PIX_MAX : v[DATA_W-1:0];
  endfunction

  assign adv     = i_ready | ~o_valid;
  assign o_ready = adv;

  // An SOF beat uses its own config immediately; later beats reuse the latched copy
  assign mode_in = i_sof ? i_mode : mode_q;
  assign thr_in  = i_sof ? i_threshold : thr_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode_q <= '0;
      thr_q  <= '0;
    end else if (i_valid && adv && i_sof) begin
      mode_q <= i_mode;
      thr_q  <= i_threshold;
    end
  end

  ps_edge_grad #(.DATA_W(DATA_W)) u_grad (
    .clk        (i_clk),
    .rst_n      (i_rstn),
    .adv        (adv),
    .r0_data    (i_r0_data),
    .r1_data    (i_r1_data),
    .r2_data    (i_r2_data),
    .valid      (i_valid),
    .sof        (i_sof),
    .mode       (mode_in),
    .thr        (thr_in),
    .gx         (gx),
    .gy         (gy),
    .grad_valid (v2),
    .grad_sof   (sof2),
    .grad_mode  (mode2),
    .grad_thr   (thr2)
  );

  always_comb begin
    ax = gx[G_W-1] ? A_W'(-gx) : A_W'(gx);
    ay = gy[G_W-1] ? A_W'(-gy) : A_W'(gy);
    sq = SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay);
  end

  always_comb begin
    l1  = {1'b0, ax3} + {1'b0, ay3};
    pix = '0;
    case (mode3)
      MODE_THRESH: pix = (sq3 > thr3) ? PIX_MAX : '0;
      MODE_MAG_L1: pix = sat_pix(l1);
      MODE_ABS_GX: pix = sat_pix({1'b0, ax3});
      MODE_ABS_GY: pix = sat_pix({1'b0, ay3});
      default:     pix = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ax3     <= '0;
      ay3     <= '0;
      sq3     <= '0;
      v3      <= 1'b0;
      sof3    <= 1'b0;
      mode3   <= '0;
      thr3    <= '0;
      o_data  <= '0;
      o_sof   <= 1'b0;
      o_valid <= 1'b0;
    end else if (adv) begin
      ax3     <= ax;
      ay3     <= ay;
      sq3     <= sq;
      v3      <= v2;
      sof3    <= sof2;
      mode3   <= mode2;
      thr3    <= thr2;
      o_data  <= pix;
      o_sof   <= sof3;
      o_valid <= v3;
    end
  end

`ifdef PS_EDGE_DIR_EN
  logic [1:0] dir;
  logic [1:0] dir3;

  // Sign test is only reached when both components are non-zero
  always_comb begin
    if ({ay, 1'b0} <= {1'b0, ax})
      dir = DIR_0;
    else if ({ax, 1'b0} <= {1'b0, ay})
      dir = DIR_90;
    else if (gx[G_W-1] == gy[G_W-1])
      dir = DIR_45;
    else
      dir = DIR_135;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dir3  <= '0;
      o_dir <= '0;
    end else if (adv) begin
      dir3  <= dir;
      o_dir <= dir3;
    end
  end
`endif

endmodule

// File: tb/tb_ps_edge_filter.sv
// Self-checking bench for ps_edge_filter (DATA_W=8): directed windows plus random traffic
// against an arithmetic Sobel reference; o_dir is also checked when PS_EDGE_DIR_EN is defined.
module tb_ps_edge_filter;

  localparam int DATA_W  = 8;
  localparam int SQ_W    = 2 * DATA_W + 5;
  localparam int PIX_MAX = (1 << DATA_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3*DATA_W-1:0] r0_data, r1_data, r2_data;
  logic                sof, valid, ready_out, ready_in;
  logic [1:0]          mode;
  logic [SQ_W-1:0]     threshold;
  logic [DATA_W-1:0]   data_out;
  logic                sof_out, valid_out;
`ifdef PS_EDGE_DIR_EN
  logic [1:0]          dir_out;
`endif

  ps_edge_filter #(.DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rstn      (rst_n),
    .i_r0_data   (r0_data),
    .i_r1_data   (r1_data),
    .i_r2_data   (r2_data),
    .i_sof       (sof),
    .i_valid     (valid),
    .o_ready     (ready_out),
    .i_mode      (mode),
    .i_threshold (threshold),
    .o_data      (data_out),
    .o_sof       (sof_out),
    .o_valid     (valid_out),
    .i_ready     (ready_in)
`ifdef PS_EDGE_DIR_EN
    ,
    .o_dir       (dir_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit sof;
    int dir;
    int acc;
  } exp_t;

  exp_t q[$];
  int   win [3][3];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cfg_mode = 0;
  int   cfg_thr = 0;
  bit   last_acc = 0;
  bit   lat_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input logic [3*DATA_W-1:0] row, input int c);
    return int'(row[c*DATA_W +: DATA_W]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int ref_pixel(input int gx, input int gy, input int m, input int thr);
    case (m)
      0:       return (gx * gx + gy * gy > thr) ? PIX_MAX : 0;
      1:       return imin(iabs(gx) + iabs(gy), PIX_MAX);
      2:       return imin(iabs(gx), PIX_MAX);
      default: return imin(iabs(gy), PIX_MAX);
    endcase
  endfunction

  function automatic int ref_dir(input int gx, input int gy);
    if (2 * iabs(gy) <= iabs(gx)) return 0;
    if (2 * iabs(gx) <= iabs(gy)) return 2;
    return ((gx > 0) == (gy > 0)) ? 1 : 3;
  endfunction

  task automatic drive_win();
    for (int c = 0; c < 3; c++) begin
      r0_data[c*DATA_W +: DATA_W] = 8'(win[0][c]);
      r1_data[c*DATA_W +: DATA_W] = 8'(win[1][c]);
      r2_data[c*DATA_W +: DATA_W] = 8'(win[2][c]);
    end
  endtask

  task automatic col_win(input int l, input int m, input int r);
    for (int k = 0; k < 3; k++) begin
      win[k][0] = l;
      win[k][1] = m;
      win[k][2] = r;
    end
  endtask

  task automatic rand_win();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = ($urandom_range(0, 3) == 0) ? 255 * int'($urandom_range(0, 1))
                                                : int'($urandom_range(0, 255));
  endtask

  // One clock: check outputs at the falling edge, record accepted beats, advance.
  task automatic cycle();
    exp_t e;
    int   gx, gy;
    @(negedge clk);
    if (valid_out) begin
      if (q.size() == 0) begin
        check("spurious_valid", valid_out, 1'b0);
      end else begin
        check(ready_in ? "data" : "held_data", data_out, q[0].data);
        check(ready_in ? "sof" : "held_sof", sof_out, q[0].sof);
`ifdef PS_EDGE_DIR_EN
        check("dir", dir_out, q[0].dir);
`endif
        if (!ready_in) check("ready_stall", ready_out, 1'b0);
        if (ready_in) begin
          if (lat_chk) check("latency", cyc - q[0].acc, 4);
          void'(q.pop_front());
        end
      end
    end else begin
      check("ready_idle", ready_out, 1'b1);
    end
    last_acc = 0;
    if (valid && ready_out) begin
      if (sof) begin
        cfg_mode = int'(mode);
        cfg_thr  = int'(threshold);
      end
      gx = (pix(r0_data, 0) - pix(r0_data, 2)) + 2 * (pix(r1_data, 0) - pix(r1_data, 2))
         + (pix(r2_data, 0) - pix(r2_data, 2));
      gy = (pix(r0_data, 0) - pix(r2_data, 0)) + 2 * (pix(r0_data, 1) - pix(r2_data, 1))
         + (pix(r0_data, 2) - pix(r2_data, 2));
      e.data = ref_pixel(gx, gy, cfg_mode, cfg_thr);
      e.sof  = sof;
      e.dir  = ref_dir(gx, gy);
      e.acc  = cyc;
      q.push_back(e);
      last_acc = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input bit s, input int m, input int thr);
    bit done = 0;
    drive_win();
    sof       = s;
    mode      = 2'(m);
    threshold = SQ_W'(thr);
    valid     = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      cycle();
      done = last_acc;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    sof   = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    valid     = 1'b0;
    sof       = 1'b0;
    ready_in  = 1'b1;
    mode      = '0;
    threshold = '0;
    col_win(0, 0, 0);
    drive_win();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 1'b0);
    check("rst_sof", sof_out, 1'b0);
    check("rst_data", data_out, '0);
`ifdef PS_EDGE_DIR_EN
    check("rst_dir", dir_out, '0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", ready_out, 1'b1);

    // directed windows, unstalled, with latency checking
    lat_chk = 1;
    col_win(100, 100, 100);
    send(1, 0, 0);              // flat -> 0x00
    col_win(255, 128, 0);
    send(1, 2, 0);              // ABS_GX -> 0xFF
    send(1, 3, 0);              // ABS_GY -> 0x00
    send(1, 0, 1000000);        // 1040400 > thr -> 0xFF
    col_win(10, 0, 0);
    send(1, 1, 0);              // MAG_L1 -> 0x28, dir 0
    win = '{'{20, 10, 0}, '{10, 0, 0}, '{0, 0, 0}};
    send(0, 1, 0);              // Gx=Gy=40 -> 0x50, dir 1
    idle(6);

    // mode change without SOF is ignored until the next SOF
    col_win(10, 0, 0);
    send(1, 0, 0);              // THRESH -> 0xFF
    send(0, 2, 5000);           // still THRESH thr=0 -> 0xFF
    send(1, 2, 0);              // ABS_GX -> 0x28
    send(0, 3, 0);              // still ABS_GX -> 0x28
    idle(6);
    lat_chk = 0;

    // 8-beat stream with a 3-cycle downstream stall in the middle
    k = 0;
    rand_win();
    for (int c = 0; c < 40 && k < 8; c++) begin
      drive_win();
      valid     = 1'b1;
      sof       = (k == 0);
      mode      = 2'd1;
      threshold = '0;
      ready_in  = !(c >= 6 && c <= 8);
      cycle();
      if (last_acc) begin
        k++;
        rand_win();
      end
    end
    check("stream_accepted", k, 8);
    ready_in = 1'b1;
    idle(8);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      rand_win();
      drive_win();
      valid     = ($urandom_range(0, 9) < 7);
      sof       = ($urandom_range(0, 9) == 0);
      mode      = 2'($urandom_range(0, 3));
      threshold = SQ_W'($urandom_range(0, 200000));
      ready_in  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    ready_in = 1'b1;
    valid    = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
    check("drain_empty", q.size(), 0);

    // asynchronous reset with four beats in flight
    col_win(10, 0, 0);
    send(1, 2, 0);
    send(0, 2, 0);
    send(0, 2, 0);
    send(0, 2, 0);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid_out, 1'b0);
    check("midrst_data", data_out, '0);
    check("midrst_sof", sof_out, 1'b0);
    q.delete();
    cfg_mode = 0;
    cfg_thr  = 0;
    #3 rst_n = 1'b1;
    idle(10);
    // non-SOF beat after reset runs with reset config (THRESH, thr=0)
    lat_chk = 1;
    send(0, 2, 7);
    idle(8);
    check("final_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
